// File: rtl/pe_array_sequencer.sv
// Sequencer for one convolution layer on the PE array: streams weights into the PEs,
// primes the line buffer, paces the MAC/adder/pool strobes and loops over filter banks.
module pe_array_sequencer #(
    parameter int N_PE      = 16,
    parameter int ADDR_FIFO = 8,
    parameter int KTAPS     = 9,
    parameter int MAC_LAT   = 2,
    parameter int BANK_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_FIFO-1:0] cfg_row_length,
    input  logic [ADDR_FIFO-1:0] cfg_num_rows,
    input  logic [BANK_W-1:0]    cfg_num_banks,
    input  logic                 cfg_pool_enable,
    input  logic                 cfg_nl_enable,
    input  logic [2:0]           cfg_nl_type,
    input  logic [2:0]           cfg_pool_nl,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N_PE-1:0]      shifting_filter,
    output logic                 line_buffer_reset,
    output logic                 shifting_line,
    output logic [ADDR_FIFO-1:0] row_length,
    output logic                 mac_enable,
    output logic                 adder_enable,
    output logic                 final_filter_bank,
    output logic                 line_buffer_reset_pool,
    output logic                 shifting_line_pool,
    output logic [ADDR_FIFO-1:0] row_length_pool,
    output logic                 nl_enable,
    output logic                 pool_enable,
    output logic [2:0]           nl_type,
    output logic [2:0]           pool_nl,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);
    localparam int PE_W  = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam int TAP_W = (KTAPS > 1) ? $clog2(KTAPS) : 1;
    localparam int DRN_W = $clog2(MAC_LAT + 2);

    typedef enum logic [2:0] {IDLE, FLT_LOAD, LB_RESET, LB_FILL, COMPUTE, DRAIN, DONE} state_t;

    state_t               state, state_n;
    logic [PE_W-1:0]      pe, pe_n;
    logic [TAP_W-1:0]     tap, tap_n;
    logic [ADDR_FIFO-1:0] col, col_n, row, row_n, num_rows_q;
    logic [BANK_W-1:0]    bank, bank_n, num_banks_q;
    logic [DRN_W-1:0]     drn, drn_n;
    logic [N_PE-1:0]      sf_n;
    logic                 sl_n, lbr_n, lbrp_n, mac_n, done_n, err_n, latch;
    logic                 xfer, col_last, last_bank;
    logic [MAC_LAT-1:0]   mac_pipe;

    assign in_ready          = (state == FLT_LOAD) || (state == LB_FILL) || (state == COMPUTE);
    assign xfer              = in_valid && in_ready;
    assign busy              = (state != IDLE);
    assign col_last          = (col == row_length - ADDR_FIFO'(1));
    assign last_bank         = (bank == num_banks_q - BANK_W'(1));
    assign final_filter_bank = busy && last_bank;
    assign adder_enable      = mac_pipe[MAC_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        pe_n    = pe;
        tap_n   = tap;
        col_n   = col;
        row_n   = row;
        bank_n  = bank;
        drn_n   = drn;
        sf_n    = '0;
        sl_n    = 1'b0;
        lbr_n   = 1'b0;
        lbrp_n  = 1'b0;
        mac_n   = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        latch   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_row_length < ADDR_FIFO'(3) || cfg_num_rows < ADDR_FIFO'(3) ||
                        cfg_num_banks == '0) begin
                        err_n = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        bank_n  = '0;
                        pe_n    = '0;
                        tap_n   = '0;
                        state_n = FLT_LOAD;
                    end
                end
            end
            FLT_LOAD: begin
                if (xfer) begin
                    sf_n = N_PE'(1) << pe;
                    if (tap == TAP_W'(KTAPS - 1)) begin
                        tap_n = '0;
                        if (pe == PE_W'(N_PE - 1)) begin
                            pe_n    = '0;
                            state_n = LB_RESET;
                        end else begin
                            pe_n = pe + PE_W'(1);
                        end
                    end else begin
                        tap_n = tap + TAP_W'(1);
                    end
                end
            end
            LB_RESET: begin
                lbr_n   = 1'b1;
                lbrp_n  = pool_enable;
                col_n   = '0;
                row_n   = '0;
                state_n = LB_FILL;
            end
            LB_FILL: begin
                if (xfer) begin
                    sl_n  = 1'b1;
                    col_n = col_last ? '0 : col + ADDR_FIFO'(1);
                    row_n = col_last ? row + ADDR_FIFO'(1) : row;
                    // Two full rows plus two pixels primes the first 3x3 window.
                    if (row == ADDR_FIFO'(2) && col == ADDR_FIFO'(1)) state_n = COMPUTE;
                end
            end
            COMPUTE: begin
                if (xfer) begin
                    sl_n  = 1'b1;
                    mac_n = (col >= ADDR_FIFO'(2));
                    if (row == num_rows_q - ADDR_FIFO'(1) && col_last) begin
                        drn_n   = '0;
                        state_n = DRAIN;
                    end else begin
                        col_n = col_last ? '0 : col + ADDR_FIFO'(1);
                        row_n = col_last ? row + ADDR_FIFO'(1) : row;
                    end
                end
            end
            DRAIN: begin
                if (drn == DRN_W'(MAC_LAT)) begin
                    drn_n = '0;
                    if (last_bank) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        bank_n  = bank + BANK_W'(1);
                        pe_n    = '0;
                        tap_n   = '0;
                        state_n = FLT_LOAD;
                    end
                end else begin
                    drn_n = drn + DRN_W'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe                     <= '0;
            tap                    <= '0;
            col                    <= '0;
            row                    <= '0;
            bank                   <= '0;
            drn                    <= '0;
            num_rows_q             <= '0;
            num_banks_q            <= '0;
            shifting_filter        <= '0;
            shifting_line          <= 1'b0;
            line_buffer_reset      <= 1'b0;
            line_buffer_reset_pool <= 1'b0;
            mac_enable             <= 1'b0;
            mac_pipe               <= '0;
            shifting_line_pool     <= 1'b0;
            done                   <= 1'b0;
            cfg_err                <= 1'b0;
            row_length             <= '0;
            row_length_pool        <= '0;
            nl_enable              <= 1'b0;
            pool_enable            <= 1'b0;
            nl_type                <= '0;
            pool_nl                <= '0;
        end else begin
            pe                     <= pe_n;
            tap                    <= tap_n;
            col                    <= col_n;
            row                    <= row_n;
            bank                   <= bank_n;
            drn                    <= drn_n;
            shifting_filter        <= sf_n;
            shifting_line          <= sl_n;
            line_buffer_reset      <= lbr_n;
            line_buffer_reset_pool <= lbrp_n;
            mac_enable             <= mac_n;
            done                   <= done_n;
            cfg_err                <= err_n;
            // mac -> adder delay line, then one more stage to the pool line buffer
            mac_pipe[0] <= mac_enable;
            for (int i = 1; i < MAC_LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
            shifting_line_pool <= adder_enable && pool_enable;
            if (latch) begin
                row_length      <= cfg_row_length;
                row_length_pool <= cfg_row_length - ADDR_FIFO'(2);
                num_rows_q      <= cfg_num_rows;
                num_banks_q     <= cfg_num_banks;
                nl_enable       <= cfg_nl_enable;
                pool_enable     <= cfg_pool_enable;
                nl_type         <= cfg_nl_type;
                pool_nl         <= cfg_pool_nl;
            end
        end
    end
endmodule

// File: tb/tb_pe_array_sequencer.sv
// Scoreboard bench for pe_array_sequencer: a layer-level model queues the expected
// strobe stream per configuration and a monitor compares whatever the DUT emits.
module tb_pe_array_sequencer;
    localparam int N_PE = 4;
    localparam int AF   = 8;
    localparam int KT   = 9;
    localparam int ML   = 2;
    localparam int BW   = 6;

    logic clk, rst_n, start, in_valid, in_ready;
    logic [AF-1:0] cfg_row_length, cfg_num_rows, row_length, row_length_pool;
    logic [BW-1:0] cfg_num_banks;
    logic cfg_pool_enable, cfg_nl_enable;
    logic [2:0] cfg_nl_type, cfg_pool_nl, nl_type, pool_nl;
    logic [N_PE-1:0] shifting_filter;
    logic line_buffer_reset, shifting_line, mac_enable, adder_enable, final_filter_bank;
    logic line_buffer_reset_pool, shifting_line_pool, nl_enable, pool_enable;
    logic busy, done, cfg_err;

    pe_array_sequencer #(.N_PE(N_PE), .ADDR_FIFO(AF), .KTAPS(KT), .MAC_LAT(ML), .BANK_W(BW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_row_length(cfg_row_length), .cfg_num_rows(cfg_num_rows),
        .cfg_num_banks(cfg_num_banks), .cfg_pool_enable(cfg_pool_enable),
        .cfg_nl_enable(cfg_nl_enable), .cfg_nl_type(cfg_nl_type), .cfg_pool_nl(cfg_pool_nl),
        .in_valid(in_valid), .in_ready(in_ready), .shifting_filter(shifting_filter),
        .line_buffer_reset(line_buffer_reset), .shifting_line(shifting_line),
        .row_length(row_length), .mac_enable(mac_enable), .adder_enable(adder_enable),
        .final_filter_bank(final_filter_bank), .line_buffer_reset_pool(line_buffer_reset_pool),
        .shifting_line_pool(shifting_line_pool), .row_length_pool(row_length_pool),
        .nl_enable(nl_enable), .pool_enable(pool_enable), .nl_type(nl_type), .pool_nl(pool_nl),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_PE-1:0] sf;
        logic            sl;
        logic            mac;
        logic            ffb;
    } xrec_t;

    typedef struct packed {
        logic lbr;
        logic lbrp;
        logic dn;
        logic err;
        int   idx;
    } crec_t;

    xrec_t xq[$];
    crec_t cq[$];
    int  n_checks = 0, n_fail = 0;
    bit  sb_on = 1'b0, done_seen = 1'b0, cur_pool = 1'b0, xfer_next = 1'b0, adder_last = 1'b0;
    int  xpopped = 0, mac_cnt = 0, add_cnt = 0, slp_cnt = 0, since_sl = 0;
    logic [ML-1:0] mac_hist = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected strobe stream for one layer, described in terms of the layer
    // itself: weight words per PE, then every pixel of the image in raster order,
    // with a MAC whenever a complete 3x3 window ends on that pixel.
    task automatic build(input int rl, input int nr, input int nb, input bit pool);
        int idx;
        xrec_t x;
        crec_t c;
        idx = 0;
        xq.delete();
        cq.delete();
        for (int b = 0; b < nb; b++) begin
            for (int p = 0; p < N_PE; p++) begin
                for (int t = 0; t < KT; t++) begin
                    x.sf = N_PE'(1) << p; x.sl = 1'b0; x.mac = 1'b0; x.ffb = (b == nb - 1);
                    xq.push_back(x);
                    idx++;
                end
            end
            c.lbr = 1'b1; c.lbrp = pool; c.dn = 1'b0; c.err = 1'b0; c.idx = idx;
            cq.push_back(c);
            for (int r = 0; r < nr; r++) begin
                for (int col = 0; col < rl; col++) begin
                    x.sf = '0; x.sl = 1'b1; x.mac = (r >= 2 && col >= 2); x.ffb = (b == nb - 1);
                    xq.push_back(x);
                    idx++;
                end
            end
        end
        c.lbr = 1'b0; c.lbrp = 1'b0; c.dn = 1'b1; c.err = 1'b0; c.idx = idx;
        cq.push_back(c);
    endtask

    initial begin : monitor
        logic  strobe;
        xrec_t ex;
        crec_t ec;
        forever begin
            @(posedge clk);
            #1;
            if (sb_on && rst_n) begin
                strobe = (shifting_filter != '0) || shifting_line;
                check("xfer_strobe", 64'(strobe), 64'(xfer_next));
                if (strobe) begin
                    if (xq.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL stream_extra: got sf=0x%0h sl=%0b, expected no strobe", shifting_filter, shifting_line);
                    end else begin
                        ex = xq.pop_front();
                        check("stream_rec", 64'({shifting_filter, shifting_line, mac_enable, final_filter_bank}), 64'(ex));
                        xpopped++;
                    end
                end else if (mac_enable) begin
                    check("mac_alone", 64'(mac_enable), 64'(0));
                end
                check("adder_delay", 64'(adder_enable), 64'(mac_hist[ML-1]));
                check("pool_delay", 64'(shifting_line_pool), 64'(adder_last && cur_pool));
                if (mac_enable) mac_cnt++;
                if (adder_enable) add_cnt++;
                if (shifting_line_pool) slp_cnt++;
                if (shifting_line) since_sl = 0; else since_sl++;
                if (line_buffer_reset || line_buffer_reset_pool || done || cfg_err) begin
                    if (cq.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL ctrl_extra: got lbr=%0b lbrp=%0b done=%0b err=%0b, expected none",
                                 line_buffer_reset, line_buffer_reset_pool, done, cfg_err);
                    end else begin
                        ec = cq.pop_front();
                        check("ctrl_rec", 64'({line_buffer_reset, line_buffer_reset_pool, done, cfg_err}),
                              64'({ec.lbr, ec.lbrp, ec.dn, ec.err}));
                        check("ctrl_order", 64'(xpopped), 64'(ec.idx));
                    end
                end
                if (done) begin
                    check("done_gap", 64'(since_sl), 64'(ML + 1));
                    done_seen = 1'b1;
                end
                mac_hist   = {mac_hist[ML-2:0], mac_enable};
                adder_last = adder_enable;
            end else begin
                mac_hist   = '0;
                adder_last = 1'b0;
                since_sl   = 0;
            end
            @(negedge clk);
            #1;
            xfer_next = in_valid && in_ready;
        end
    end

    task automatic run(input int rl, input int nr, input int nb, input bit pool,
                       input int mode, input bit stray);
        int tout;
        bit stray_done;
        logic [2:0] nlt, pnl;
        logic nle;
        nlt = 3'($urandom_range(0, 7));
        pnl = 3'($urandom_range(0, 7));
        nle = 1'($urandom_range(0, 1));
        build(rl, nr, nb, pool);
        cur_pool = pool; mac_cnt = 0; add_cnt = 0; slp_cnt = 0; xpopped = 0; done_seen = 1'b0;
        @(negedge clk);
        cfg_row_length = AF'(rl); cfg_num_rows = AF'(nr); cfg_num_banks = BW'(nb);
        cfg_pool_enable = pool; cfg_nl_enable = nle; cfg_nl_type = nlt; cfg_pool_nl = pnl;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_start", 64'(busy), 64'(1));
        check("row_length", 64'(row_length), 64'(rl));
        check("row_length_pool", 64'(row_length_pool), 64'(rl - 2));
        check("latched_cfg", 64'({pool_enable, nl_enable, nl_type, pool_nl}), 64'({pool, nle, nlt, pnl}));
        tout = 0;
        stray_done = 1'b0;
        while (!done_seen && tout < 6000) begin
            @(negedge clk);
            start = 1'b0;
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ~in_valid;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (stray && !stray_done && mac_cnt > 0) begin
                start = 1'b1;
                cfg_row_length = AF'(7);
                stray_done = 1'b1;
            end
            tout++;
        end
        if (!done_seen) begin
            n_checks++; n_fail++;
            $display("FAIL run_timeout: got no done within %0d cycles, expected done", tout);
        end
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_after_done", 64'(busy), 64'(0));
        check("stream_left", 64'(xq.size()), 64'(0));
        check("ctrl_left", 64'(cq.size()), 64'(0));
        check("mac_count", 64'(mac_cnt), 64'(nb * (nr - 2) * (rl - 2)));
        check("adder_count", 64'(add_cnt), 64'(nb * (nr - 2) * (rl - 2)));
        check("pool_count", 64'(slp_cnt), 64'(pool ? nb * (nr - 2) * (rl - 2) : 0));
        check("cfg_retained", 64'({row_length, nl_type}), 64'({AF'(rl), nlt}));
    endtask

    task automatic bad_start(input int rl, input int nr, input int nb);
        crec_t c;
        xq.delete();
        cq.delete();
        xpopped = 0;
        c.lbr = 1'b0; c.lbrp = 1'b0; c.dn = 1'b0; c.err = 1'b1; c.idx = 0;
        cq.push_back(c);
        @(negedge clk);
        cfg_row_length = AF'(rl); cfg_num_rows = AF'(nr); cfg_num_banks = BW'(nb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("err_busy", 64'(busy), 64'(0));
        check("err_seen", 64'(cq.size()), 64'(0));
    endtask

    initial begin
        int tout;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        cfg_row_length = '0; cfg_num_rows = '0; cfg_num_banks = '0;
        cfg_pool_enable = 1'b0; cfg_nl_enable = 1'b0; cfg_nl_type = '0; cfg_pool_nl = '0;
        @(posedge clk);
        #1;
        check("reset_ctrl", 64'({busy, in_ready, done, cfg_err, final_filter_bank}), 64'(0));
        check("reset_strobes", 64'({shifting_filter, shifting_line, mac_enable, adder_enable,
                                    line_buffer_reset, line_buffer_reset_pool, shifting_line_pool}), 64'(0));
        check("reset_cfg", 64'({row_length, row_length_pool, nl_type, pool_nl, nl_enable, pool_enable}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        sb_on = 1'b1;

        run(5, 4, 1, 1'b0, 0, 1'b0);
        run(5, 4, 1, 1'b0, 1, 1'b0);
        run(5, 4, 3, 1'b1, 0, 1'b0);
        bad_start(2, 4, 1);
        bad_start(5, 2, 1);
        bad_start(5, 4, 0);
        run(5, 4, 2, 1'b1, 2, 1'b1);

        // Asynchronous reset one cycle after a MAC strobe, mid-COMPUTE.
        sb_on = 1'b0;
        @(negedge clk);
        cfg_row_length = AF'(5); cfg_num_rows = AF'(4); cfg_num_banks = BW'(1);
        cfg_pool_enable = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        tout = 0;
        do begin
            @(posedge clk);
            #1;
            tout++;
        end while (!mac_enable && tout < 500);
        check("rst_test_mac_seen", 64'(mac_enable), 64'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", 64'({busy, in_ready, done, cfg_err, final_filter_bank}), 64'(0));
        check("rst_strobes", 64'({shifting_filter, shifting_line, mac_enable, adder_enable,
                                  line_buffer_reset, line_buffer_reset_pool, shifting_line_pool}), 64'(0));
        check("rst_cfg", 64'({row_length, row_length_pool, pool_enable}), 64'(0));
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_quiet", 64'({adder_enable, shifting_line_pool, busy}), 64'(0));
        end
        sb_on = 1'b1;
        run(4, 3, 1, 1'b1, 2, 1'b0);

        for (int k = 0; k < 3; k++) begin
            run($urandom_range(3, 8), $urandom_range(3, 6), $urandom_range(1, 3),
                1'($urandom_range(0, 1)), 2, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pe_array_sequencer.md
Name: pe_array_sequencer

Overview:
- Controller-side driver of the PE-array control bundle: generates shifting_filter, line-buffer reset/shift, mac/adder enables, final_filter_bank, pool and NL controls for one convolution layer.
- Sits between the layer-config/top controller and the PE array.
- Paces an input pixel/weight stream with a valid/ready handshake.
- Loops over filter banks until the layer is done.

Parameters:
N_PE, 16, number of PEs; width of shifting_filter
ADDR_FIFO, 8, width of row-length and pixel counters
KTAPS, 9, weights per PE per filter bank (3x3 kernel)
MAC_LAT, 2, cycles from mac_enable to a valid MAC result for the adder
BANK_W, 6, width of filter-bank count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle layer start pulse
cfg_row_length  in  ADDR_FIFO  input row width in pixels (>=3)
cfg_num_rows  in  ADDR_FIFO  input rows (>=3)
cfg_num_banks  in  BANK_W  filter banks (>=1)
cfg_pool_enable  in  1  pooling enabled
cfg_nl_enable  in  1  nonlinearity enabled
cfg_nl_type  in  3  NL select
cfg_pool_nl  in  3  pool/NL ordering select
in_valid  in  1  weight/pixel word available on the array input bus
in_ready  out  1  sequencer accepts a word this cycle
shifting_filter  out  N_PE  one-hot weight shift strobe
line_buffer_reset  out  1  conv line-buffer clear
shifting_line  out  1  conv line-buffer shift
row_length  out  ADDR_FIFO  latched cfg_row_length
mac_enable  out  1  MAC strobe
adder_enable  out  1  adder-tree strobe
final_filter_bank  out  1  high throughout the last bank
line_buffer_reset_pool  out  1  pool line-buffer clear
shifting_line_pool  out  1  pool line-buffer shift
row_length_pool  out  ADDR_FIFO  cfg_row_length-2
nl_enable, pool_enable  out  1 each  latched config
nl_type, pool_nl  out  3 each  latched config
busy  out  1  not IDLE
done  out  1  one-cycle completion pulse
cfg_err  out  1  one-cycle pulse on an illegal config at start

Behaviour:
- Reset: every output 0, FSM = IDLE, all counters 0.
- Transfer: in_valid && in_ready. in_ready = 1 in FLT_LOAD, LB_FILL and COMPUTE; 0 elsewhere. All strobes are registered (1-cycle latency from the transfer).
- IDLE:
  - start with row_length<3, num_rows<3 or num_banks==0 -> pulse cfg_err, stay in IDLE.
  - start with a legal config -> latch all cfg_* inputs (row_length, row_length_pool, nl/pool outputs valid from the next cycle), bank=0, go to FLT_LOAD.
- start while busy: ignored.
- FLT_LOAD:
  - Each transfer asserts shifting_filter[pe] (one-hot, pe=0..N_PE-1) and increments tap 0..KTAPS-1.
  - At tap wrap, pe++.
  - After transfer pe=N_PE-1, tap=KTAPS-1 -> LB_RESET.
- LB_RESET: line_buffer_reset=1 for one cycle; line_buffer_reset_pool=1 too if pool_enable -> LB_FILL. Column and row counters cleared.
- LB_FILL:
  - Each transfer: shifting_line=1, advance col (wraps at row_length-1, then row++).
  - After 2*row_length+2 transfers -> COMPUTE.
- COMPUTE:
  - Each transfer: shifting_line=1; mac_enable=1 iff col>=2.
  - After the transfer at row=num_rows-1, col=row_length-1 -> DRAIN.
- adder_enable: mac_enable delayed exactly MAC_LAT cycles (shift register; keeps running through DRAIN).
- shifting_line_pool: adder_enable delayed 1 cycle, gated by pool_enable.
- DRAIN: MAC_LAT+1 cycles, no transfers. Then:
  - bank<num_banks-1 -> bank++, reset pe/tap, go to FLT_LOAD.
  - otherwise -> DONE.
- final_filter_bank = busy && bank==num_banks-1.
- DONE: done=1 for one cycle -> IDLE; all strobes 0; latched config retained.
- in_valid low stalls every counter; no strobe fires without a transfer.
- Counter arithmetic is unsigned ADDR_FIFO bits. Illegal configs are rejected, so no wrap occurs.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The delay pipelines are cleared, so no stray adder_enable appears.

Test Plan:
- N_PE=4, KTAPS=9, in_valid held high, one bank:
  - shifting_filter = 0001 for 9 cycles, then 0010, 0100, 1000 (36 total), then one line_buffer_reset pulse.
- row_length=5, num_rows=4, one bank, pool off, in_valid high -> 12 fill shifts, 8 compute shifts, exactly 6 mac_enable pulses (groups of 3), 6 adder_enable pulses 2 cycles later, done 3 cycles after the last shift.
- Same config with in_valid toggling 1/0 -> identical pulse counts; mac_enable only on transfer cycles; shifting_filter never asserted while in_valid=0.
- num_banks=3, pool_enable=1 -> FLT_LOAD entered 3 times; final_filter_bank high only in bank 2; row_length_pool=3; 18 shifting_line_pool pulses total; 3 line_buffer_reset_pool pulses.
- start with cfg_row_length=2 -> cfg_err pulse, busy stays 0. A start during COMPUTE -> ignored, counts unchanged.
- Assert rst_n=0 in COMPUTE, one cycle after a mac_enable -> all outputs 0 immediately; no adder_enable after release; a fresh start runs normally.
